// File: rtl/watch_pkg.sv
// Shared definitions for the watch-format <-> millisecond-count converters.
// Field widths, unit constants, range check and the conversion FSM states.
package watch_pkg;

  localparam int MS_PER_S   = 1000;
  localparam int S_PER_MIN  = 60;
  localparam int MIN_PER_HR = 60;
  localparam int HR_LIMIT   = 100;

  localparam int MS_W  = 10;
  localparam int S_W   = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 7;

  // 99:59:59.999 = 359 999 999 ms needs 29 bits.
  localparam int ACC_W = 29;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_HR  = 2'd1,
    MUL_MIN = 2'd2,
    MUL_S   = 2'd3
  } state_t;

  typedef enum logic {
    K_60   = 1'b0,
    K_1000 = 1'b1
  } k_sel_t;

  function automatic logic fields_legal(
    input logic [MS_W-1:0]  ms,
    input logic [S_W-1:0]   s,
    input logic [MIN_W-1:0] min,
    input logic [HR_W-1:0]  hr
  );
    return (ms  < MS_W'(MS_PER_S))    &&
           (s   < S_W'(S_PER_MIN))    &&
           (min < MIN_W'(MIN_PER_HR)) &&
           (hr  < HR_W'(HR_LIMIT));
  endfunction

endpackage

// File: rtl/watch_mac.sv
// Combinational acc*k + addend with k in {60, 1000}, built from shifts and
// subtracts only. Arithmetic wraps mod 2^ACC_W.
module watch_mac
  import watch_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  k_sel_t           k_sel,
  input  logic [MS_W-1:0]  addend,
  output logic [ACC_W-1:0] result
);

  logic [ACC_W-1:0] x60;
  logic [ACC_W-1:0] x1000;

  always_comb begin
    // 60 = 64 - 4, 1000 = 1024 - 16 - 8
    x60    = (acc << 6) - (acc << 2);
    x1000  = (acc << 10) - (acc << 4) - (acc << 3);
    result = ((k_sel == K_1000) ? x1000 : x60) + ACC_W'(addend);
  end

endmodule

// File: rtl/watch2count.sv
// Converts hr:min:s.ms into a flat millisecond count by Horner evaluation,
// one shared shift-add MAC step per cycle.
module watch2count
  import watch_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [9:0]      ms,
  input  logic [5:0]      s,
  input  logic [5:0]      min,
  input  logic [6:0]      hr,
  output logic [BITS-1:0] count,
  output logic            busy,
  output logic            done,
  output logic            err
);

  // Handshake: start is taken only while busy=0 (IDLE); each accepted start
  // yields exactly one done pulse (err qualifies it), unless reset intervenes.
  // start seen while busy is dropped.

  state_t           state;
  state_t           state_nxt;
  logic [MS_W-1:0]  ms_r;
  logic [S_W-1:0]   s_r;
  logic [MIN_W-1:0] min_r;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mac_out;
  logic [MS_W-1:0]  mac_addend;
  k_sel_t           mac_k;
  logic             legal;

  assign legal = fields_legal(ms, s, min, hr);

  watch_mac u_mac (
    .acc    (acc),
    .k_sel  (mac_k),
    .addend (mac_addend),
    .result (mac_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && legal) state_nxt = MUL_HR;
      MUL_HR:  state_nxt = MUL_MIN;
      MUL_MIN: state_nxt = MUL_S;
      MUL_S:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    mac_k      = K_60;
    mac_addend = '0;
    case (state)
      MUL_HR:  mac_addend = MS_W'(min_r);
      MUL_MIN: mac_addend = MS_W'(s_r);
      MUL_S: begin
        mac_k      = K_1000;
        mac_addend = ms_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_r  <= '0;
      s_r   <= '0;
      min_r <= '0;
      acc   <= '0;
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ms_r  <= ms;
            s_r   <= s;
            min_r <= min;
            if (legal) begin
              acc <= ACC_W'(hr);
            end else begin
              // Rejected request answers immediately with a zero count.
              count <= '0;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        MUL_HR, MUL_MIN: acc <= mac_out;
        MUL_S: begin
          count <= BITS'(mac_out);
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
